// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

   localparam int unsigned DIV_W_DEF     = 24;
   localparam int unsigned DEFAULT_DIV_C = 12_000_000;

   typedef logic [DIV_W_DEF-1:0] div_t;

   // Channel-select width; a single channel still needs a 1-bit select port.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor, pending flag, registered outputs.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W       = DIV_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] wdiv_i,
   output logic             clk_o,
   output logic             tick_o,
   output logic             pend_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] act_q, act_d;
   logic [DIV_W-1:0] shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;

   logic [DIV_W:0]   act_p1;
   logic [DIV_W-1:0] hi;
   logic             at_last;

   // One extra bit so (N+1)>>1 cannot overflow at N = 2**DIV_W-1.
   assign act_p1  = {1'b0, act_q} + (DIV_W+1)'(1);
   assign hi      = act_p1[DIV_W:1];
   assign at_last = (cnt_q == act_q - DIV_W'(1));

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path infers a latch.
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      clk_d  = clk_q;
      tick_d = tick_q;

      if (sync_i || !en_i) begin
         cnt_d  = '0;
         clk_d  = 1'b0;
         tick_d = 1'b0;
         if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
         end
      end else begin
         clk_d  = (cnt_q < hi);
         tick_d = at_last;
         cnt_d  = at_last ? '0 : cnt_q + DIV_W'(1);
         if (at_last && pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
         end
      end

      // A write always wins over the apply above, so a colliding write stays pending.
      if (wr_i) begin
         shd_d  = (wdiv_i == '0) ? DIV_W'(1) : wdiv_i;
         pend_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all channels update from the same pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         act_q  <= DIV_W'(DEFAULT_DIV);
         shd_q  <= DIV_W'(DEFAULT_DIV);
         pend_q <= 1'b0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = tick_q;
   assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes divisor writes and replicates channels.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 4,
   parameter  int unsigned DIV_W       = DIV_W_DEF,
   parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_C,
   localparam int unsigned CH_W        = ch_w(NUM_CH)
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] cfg_pending,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   // Selects at or beyond NUM_CH match no instance, so such writes are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
      logic wr_sel;
      assign wr_sel = cfg_wr && (cfg_ch == CH_W'(i));

      clk_div_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in (clk_in),
         .rst_n  (rst_n),
         .en_i   (en[i]),
         .sync_i (sync),
         .wr_i   (wr_sel),
         .wdiv_i (cfg_div),
         .clk_o  (clk_out[i]),
         .tick_o (tick[i]),
         .pend_o (cfg_pending[i])
      );
   end

endmodule
